siu_niu_ob_sched: RTL and testbench

SIU_NIU_OB_SCHED -- requirements
Module: siu_niu_ob_sched

---
 rtl/siu_niu_ob_pkg.sv | 9 +
 rtl/siu_niu_par_gen.sv | 11 +
 rtl/siu_niu_ob_sched.sv | 107 ++++++++++
 tb/tb_siu_niu_ob_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/siu_niu_ob_pkg.sv
// siu_niu_ob_pkg: shared states and widths for the SIU->NIU outbound scheduler (parity option: SIU_NIU_PARITY_EN)
package siu_niu_ob_pkg;
    localparam int HDR_W     = 128;
    localparam int DATA_W    = 128;
    localparam int PAR_LANE  = 16;
    localparam int PAR_W     = DATA_W / PAR_LANE;
    localparam int BEATS_DEF = 4;
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PLD} state_e;
endpackage

// File: rtl/siu_niu_par_gen.sv
// siu_niu_par_gen: even parity per 16-bit lane of the outbound data word
module siu_niu_par_gen
    import siu_niu_ob_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [PAR_W-1:0]  par_o
);
    for (genvar i = 0; i < PAR_W; i++) begin : g_lane
        assign par_o[i] = ^data_i[PAR_LANE*i +: PAR_LANE];
    end
endmodule

// File: rtl/siu_niu_ob_sched.sv
// siu_niu_ob_sched: credit-gated round-robin header/payload scheduler toward the NIU (parity option: SIU_NIU_PARITY_EN)
module siu_niu_ob_sched
    import siu_niu_ob_pkg::*;
#(
    parameter int CREDITS = 8,
    parameter int BEATS   = BEATS_DEF
) (
    input  logic              iol2clk,
    input  logic              rst_l,
    input  logic              wack_vld,
    input  logic [HDR_W-1:0]  wack_hdr,
    output logic              wack_ack,
    input  logic              rd_vld,
    input  logic [HDR_W-1:0]  rd_hdr,
    output logic              rd_ack,
    input  logic [DATA_W-1:0] rd_pld,
    output logic              rd_pld_pop,
    input  logic              niu_sio_credit_ret,
    output logic              sio_niu_hdr_vld,
    output logic              sio_niu_datareq,
    output logic [DATA_W-1:0] sio_niu_data,
    output logic [PAR_W-1:0]  sio_niu_parity,
    output logic [3:0]        credit_cnt,
    output logic              err_credit_ovf
);
    localparam int            BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam logic [3:0]    CMAX = 4'(CREDITS);

    state_e            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_rd_q, is_rd_d, rr_rd_q, rr_rd_d;
    logic              hv_q, hv_d, dr_q, dr_d, ovf_q, ovf_d;
    logic              slot, pop, gnt_rd, gnt_wk, issue, ovf_hit;

    // a new header may follow a wack header or the last rd beat directly; rd payload beats are popped one cycle ahead
    always_comb begin
        slot    = state_q == S_IDLE || (state_q == S_HDR && !is_rd_q) || (state_q == S_PLD && beat_q == LAST);
        pop     = (state_q == S_HDR && is_rd_q) || (state_q == S_PLD && beat_q != LAST);
        gnt_rd  = rst_l && slot && cnt_q != 4'd0 && rd_vld && (!wack_vld || rr_rd_q);
        gnt_wk  = rst_l && slot && cnt_q != 4'd0 && wack_vld && !gnt_rd;
        issue   = gnt_rd || gnt_wk;
        state_d = pop ? S_PLD : issue ? S_HDR : S_IDLE;
        beat_d  = (pop && state_q == S_PLD) ? beat_q + 1'b1 : '0;
        data_d  = pop ? rd_pld : gnt_rd ? rd_hdr : gnt_wk ? wack_hdr : data_q;
        hv_d    = issue;
        dr_d    = gnt_rd;
        is_rd_d = issue ? gnt_rd : is_rd_q;
        rr_rd_d = issue ? gnt_wk : rr_rd_q;
        ovf_hit = niu_sio_credit_ret && !issue && cnt_q == CMAX;
        cnt_d   = (issue && !niu_sio_credit_ret) ? cnt_q - 4'd1 :
                  (!issue && niu_sio_credit_ret && !ovf_hit) ? cnt_q + 4'd1 : cnt_q;
        ovf_d   = ovf_q || ovf_hit;
    end

    // state and output registers; reset aborts any packet in flight
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            data_q  <= '0;
            cnt_q   <= CMAX;
            is_rd_q <= 1'b0;
            rr_rd_q <= 1'b1;
            hv_q    <= 1'b0;
            dr_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            is_rd_q <= is_rd_d;
            rr_rd_q <= rr_rd_d;
            hv_q    <= hv_d;
            dr_q    <= dr_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SIU_NIU_PARITY_EN
    logic [PAR_W-1:0] par_d, par_q;

    siu_niu_par_gen u_par (.data_i(data_d), .par_o(par_d));

    // parity registered alongside the data word it covers
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) par_q <= '0;
        else        par_q <= par_d;
    end

    assign sio_niu_parity = par_q;
`else
    assign sio_niu_parity = '0;
`endif

    assign wack_ack        = gnt_wk;
    assign rd_ack          = gnt_rd;
    assign rd_pld_pop      = pop;
    assign sio_niu_hdr_vld = hv_q;
    assign sio_niu_datareq = dr_q;
    assign sio_niu_data    = data_q;
    assign credit_cnt      = cnt_q;
    assign err_credit_ovf  = ovf_q;
endmodule

// File: tb/tb_siu_niu_ob_sched.sv
// tb_siu_niu_ob_sched: scoreboard bench for the outbound scheduler (parity option: SIU_NIU_PARITY_EN)
module tb_siu_niu_ob_sched;
`ifdef SIU_NIU_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    typedef struct packed {
        logic         hv;
        logic         dr;
        logic [127:0] d;
        logic         pl;
    } exp_t;

    logic         iol2clk = 1'b0;
    logic         rst_l, wack_vld, rd_vld, niu_sio_credit_ret;
    logic [127:0] wack_hdr, rd_hdr, rd_pld;
    logic         wack_ack, rd_ack, rd_pld_pop, sio_niu_hdr_vld, sio_niu_datareq, err_credit_ovf;
    logic [127:0] sio_niu_data;
    logic [7:0]   sio_niu_parity;
    logic [3:0]   credit_cnt;

    exp_t         exq[$];
    logic [127:0] wq[$], rq[$], pq[$], bq[$];
    logic [127:0] last_d;
    logic         grants[$];
    logic         rr_rd, ovf_m;
    int           cnt_m, n, fails;
    logic [127:0] base;

    siu_niu_ob_sched #(.CREDITS(8), .BEATS(4)) dut (
        .iol2clk(iol2clk), .rst_l(rst_l),
        .wack_vld(wack_vld), .wack_hdr(wack_hdr), .wack_ack(wack_ack),
        .rd_vld(rd_vld), .rd_hdr(rd_hdr), .rd_ack(rd_ack),
        .rd_pld(rd_pld), .rd_pld_pop(rd_pld_pop),
        .niu_sio_credit_ret(niu_sio_credit_ret),
        .sio_niu_hdr_vld(sio_niu_hdr_vld), .sio_niu_datareq(sio_niu_datareq),
        .sio_niu_data(sio_niu_data), .sio_niu_parity(sio_niu_parity),
        .credit_cnt(credit_cnt), .err_credit_ovf(err_credit_ovf)
    );

    always #5 iol2clk = ~iol2clk;

    function automatic logic [7:0] par(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return PEN ? p : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive();
        wack_vld = wq.size() != 0;
        wack_hdr = wack_vld ? wq[0] : '0;
        rd_vld   = rq.size() != 0;
        rd_hdr   = rd_vld ? rq[0] : '0;
        rd_pld   = pq.size() != 0 ? pq[0] : '0;
    endtask

    task automatic clr_model();
        exq.delete();
        last_d = '0;
        cnt_m  = 8;
        ovf_m  = 1'b0;
        rr_rd  = 1'b1;
    endtask

    task automatic clr_reqs();
        wq.delete(); rq.delete(); pq.delete(); bq.delete();
        drive();
    endtask

    task automatic q_wk(input logic [127:0] h);
        wq.push_back(h);
        drive();
    endtask

    task automatic q_rd(input logic [127:0] h, input logic [127:0] b);
        rq.push_back(h);
        for (int i = 0; i < 4; i++) begin
            pq.push_back(b + 128'(i));
            bq.push_back(b + 128'(i));
        end
        drive();
    endtask

    task automatic tick();
        exp_t e;
        logic er, ew, a_w, a_r, a_p;
        @(negedge iol2clk);
        e = '0;
        e.d = last_d;
        if (exq.size() != 0) e = exq.pop_front();
        last_d = e.d;
        chk("hdr_vld", 128'(sio_niu_hdr_vld), 128'(e.hv));
        chk("datareq", 128'(sio_niu_datareq), 128'(e.dr));
        chk("data", sio_niu_data, e.d);
        chk("parity", 128'(sio_niu_parity), 128'(par(e.d)));
        chk("pld_pop", 128'(rd_pld_pop), 128'(exq.size() != 0 && exq[0].pl));
        er = rst_l && exq.size() == 0 && cnt_m > 0 && rd_vld && (!wack_vld || rr_rd);
        ew = rst_l && exq.size() == 0 && cnt_m > 0 && wack_vld && !er;
        chk("rd_ack", 128'(rd_ack), 128'(er));
        chk("wack_ack", 128'(wack_ack), 128'(ew));
        chk("credit_cnt", 128'(credit_cnt), 128'(cnt_m));
        chk("err_ovf", 128'(err_credit_ovf), 128'(ovf_m));
        a_w = wack_ack;
        a_r = rd_ack;
        a_p = rd_pld_pop;
        if (!rst_l) clr_model();
        else begin
            if (er || ew) begin
                exq.push_back(exp_t'{1'b1, er, er ? rq[0] : wq[0], 1'b0});
                if (er) for (int i = 0; i < 4; i++) exq.push_back(exp_t'{1'b0, 1'b0, bq.pop_front(), 1'b1});
                rr_rd = ew;
                grants.push_back(er);
            end
            if (niu_sio_credit_ret && !(er || ew) && cnt_m == 8) ovf_m = 1'b1;
            else cnt_m = cnt_m + int'(niu_sio_credit_ret) - int'(er || ew);
        end
        @(posedge iol2clk);
        #1;
        if (a_w && wq.size() != 0) void'(wq.pop_front());
        if (a_r && rq.size() != 0) void'(rq.pop_front());
        if (a_p && pq.size() != 0) void'(pq.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        clr_reqs();
        clr_model();
        tick();
        tick();
        rst_l = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (wq.size() != 0 || rq.size() != 0 || exq.size() != 0); i++) tick();
        chk("drained", 128'(wq.size() + rq.size() + exq.size()), 128'(0));
    endtask

    initial begin
        n = 0;
        fails = 0;
        rst_l = 1'b0;
        niu_sio_credit_ret = 1'b0;
        clr_reqs();
        clr_model();
        repeat (2) @(posedge iol2clk);
        #1;
        chk("rst_hdr_vld", 128'(sio_niu_hdr_vld), 128'(0));
        chk("rst_data", sio_niu_data, 128'(0));
        chk("rst_credit", 128'(credit_cnt), 128'(8));
        chk("rst_ovf", 128'(err_credit_ovf), 128'(0));
        do_reset();

        q_rd(128'hDEAD_BEEF_0000_1111_2222_3333_4444_55A5, 128'd1);
        tick();
        chk("single_rd_credit", 128'(credit_cnt), 128'(7));
        drain();
        chk("single_rd_credit_end", 128'(credit_cnt), 128'(7));

        do_reset();
        grants.delete();
        for (int i = 0; i < 3; i++) begin
            q_wk(128'h1000 + 128'(i));
            q_rd(128'h2000 + 128'(i), 128'h100 * 128'(i + 1));
        end
        drain();
        chk("rr_count", 128'(grants.size()), 128'(6));
        for (int i = 0; i < 4; i++) chk("rr_order", 128'(grants[i]), 128'(i % 2 == 0));

        do_reset();
        for (int i = 0; i < 9; i++) q_wk(128'h3000 + 128'(i));
        repeat (12) tick();
        chk("stall_credit", 128'(credit_cnt), 128'(0));
        chk("stall_pending", 128'(wq.size()), 128'(1));
        niu_sio_credit_ret = 1'b1;
        tick();
        niu_sio_credit_ret = 1'b0;
        chk("ret_credit", 128'(credit_cnt), 128'(1));
        tick();
        chk("one_more_issued", 128'(wq.size()), 128'(0));
        repeat (3) tick();
        chk("stall_credit_again", 128'(credit_cnt), 128'(0));

        do_reset();
        for (int i = 0; i < 6; i++) q_wk(128'h4000 + 128'(i));
        niu_sio_credit_ret = 1'b1;
        repeat (6) tick();
        niu_sio_credit_ret = 1'b0;
        drain();
        chk("issue_ret_credit", 128'(credit_cnt), 128'(8));
        chk("issue_ret_ovf", 128'(err_credit_ovf), 128'(0));

        do_reset();
        niu_sio_credit_ret = 1'b1;
        tick();
        niu_sio_credit_ret = 1'b0;
        repeat (4) tick();
        chk("ovf_credit", 128'(credit_cnt), 128'(8));
        chk("ovf_sticky", 128'(err_credit_ovf), 128'(1));
        rst_l = 1'b0;
        #1;
        chk("ovf_cleared", 128'(err_credit_ovf), 128'(0));
        clr_model();
        tick();
        rst_l = 1'b1;

        do_reset();
        q_rd(128'h5A5A, 128'h70);
        repeat (3) tick();
        #2;
        chk("abort_beat2", sio_niu_data, 128'h71);
        rst_l = 1'b0;
        #1;
        chk("abort_hdr_vld", 128'(sio_niu_hdr_vld), 128'(0));
        chk("abort_datareq", 128'(sio_niu_datareq), 128'(0));
        chk("abort_data", sio_niu_data, 128'(0));
        chk("abort_parity", 128'(sio_niu_parity), 128'(0));
        chk("abort_pop", 128'(rd_pld_pop), 128'(0));
        chk("abort_credit", 128'(credit_cnt), 128'(8));
        clr_reqs();
        clr_model();
        repeat (2) tick();
        rst_l = 1'b1;
        repeat (6) tick();

        do_reset();
        q_wk({8{16'h0001}});
        tick();
        chk("par_lane_data", sio_niu_data, {8{16'h0001}});
        chk("par_lane_ones", 128'(sio_niu_parity), PEN ? 128'hFF : 128'h00);
        base = {$urandom, $urandom, $urandom, $urandom};
        q_rd({$urandom, $urandom, $urandom, $urandom}, base);
        q_wk({$urandom, $urandom, $urandom, $urandom});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end
endmodule
